// File: rtl/mips_cpu_lsu_pkg.sv
// Shared types and helpers for the MIPS load/store unit.
//   lsu_op_e    : CPU load/store operation code (4 bits)
//   lsu_state_e : LSU sequencer state
//   is_load()   : op issues a RAM read
//   is_store()  : op issues a RAM write
package mips_cpu_lsu_pkg;

   typedef enum logic [3:0] {
      LSU_LB  = 4'd0,
      LSU_LBU = 4'd1,
      LSU_LH  = 4'd2,
      LSU_LHU = 4'd3,
      LSU_LW  = 4'd4,
      LSU_LWL = 4'd5,
      LSU_LWR = 4'd6,
      LSU_SB  = 4'd7,
      LSU_SH  = 4'd8,
      LSU_SW  = 4'd9
   } lsu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_REQ       = 2'd1,
      ST_WAIT_DATA = 2'd2,
      ST_DONE      = 2'd3
   } lsu_state_e;

   localparam logic [3:0]  BE_NONE = 4'b0000;
   localparam logic [3:0]  BE_ALL  = 4'b1111;
   localparam logic [31:0] ONES_32 = 32'hFFFF_FFFF;

   function automatic logic is_load(input lsu_op_e op);
      logic r;
      case (op)
         LSU_LB, LSU_LBU, LSU_LH, LSU_LHU,
         LSU_LW, LSU_LWL, LSU_LWR: r = 1'b1;
         default:                  r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_store(input lsu_op_e op);
      logic r;
      case (op)
         LSU_SB, LSU_SH, LSU_SW: r = 1'b1;
         default:                r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mips_cpu_lsu_lanes.sv
// Combinational lane logic for the LSU (big-endian: lane 3 = byte offset 0).
// Ports:
//   op, k          : operation and byte offset within the word
//   store_data     : rt value for stores
//   rt_old         : current rt, merged by LWL/LWR
//   readdata       : RAM word being loaded
//   byteenable     : RAM lane enables for the access
//   writedata      : replicated store data
//   result         : aligned and extended load value
//   misaligned     : access violates natural alignment
module mips_cpu_lsu_lanes
   import mips_cpu_lsu_pkg::*;
(
   input  lsu_op_e     op,
   input  logic [1:0]  k,
   input  logic [31:0] store_data,
   input  logic [31:0] rt_old,
   input  logic [31:0] readdata,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   output logic [31:0] result,
   output logic        misaligned
);

   logic [4:0]  sh_k;       // 8*k
   logic [4:0]  sh_rk;      // 8*(3-k)
   logic [31:0] rd_shl;     // byte k moved to the top lane
   logic [31:0] rd_shr;     // byte k moved to the bottom lane
   logic [15:0] half_lane;
   logic [3:0]  be_byte;
   logic [3:0]  be_half;

   always_comb begin
      sh_k      = {k, 3'b000};
      sh_rk     = {~k, 3'b000};
      rd_shl    = readdata << sh_k;
      rd_shr    = readdata >> sh_rk;
      half_lane = k[1] ? readdata[15:0] : readdata[31:16];
      be_byte   = 4'b1000 >> k;
      be_half   = k[1] ? 4'b0011 : 4'b1100;
   end

   always_comb begin
      byteenable = BE_NONE;
      writedata  = store_data;
      result     = readdata;
      misaligned = 1'b0;
      case (op)
         LSU_LB: begin
            byteenable = be_byte;
            result     = {{24{rd_shr[7]}}, rd_shr[7:0]};
         end
         LSU_LBU: begin
            byteenable = be_byte;
            result     = {24'h00_0000, rd_shr[7:0]};
         end
         LSU_LH: begin
            byteenable = be_half;
            result     = {{16{half_lane[15]}}, half_lane};
            misaligned = k[0];
         end
         LSU_LHU: begin
            byteenable = be_half;
            result     = {16'h0000, half_lane};
            misaligned = k[0];
         end
         LSU_LW: begin
            byteenable = BE_ALL;
            result     = readdata;
            misaligned = (k != 2'b00);
         end
         // LWL: bytes k..3 fill the top of rt, the low k bytes keep rt_old
         LSU_LWL: begin
            byteenable = BE_ALL >> k;
            result     = rd_shl | (rt_old & ~(ONES_32 << sh_k));
         end
         // LWR: bytes 0..k fill the bottom of rt, the high 3-k bytes keep rt_old
         LSU_LWR: begin
            byteenable = BE_ALL << ~k;
            result     = rd_shr | (rt_old & ~(ONES_32 >> sh_rk));
         end
         LSU_SB: begin
            byteenable = be_byte;
            writedata  = {4{store_data[7:0]}};
         end
         LSU_SH: begin
            byteenable = be_half;
            writedata  = {2{store_data[15:0]}};
            misaligned = k[0];
         end
         LSU_SW: begin
            byteenable = BE_ALL;
            writedata  = store_data;
            misaligned = (k != 2'b00);
         end
         default: begin
            byteenable = BE_NONE;
         end
      endcase
   end

endmodule

// File: rtl/mips_cpu_lsu.sv
// MIPS load/store unit: one CPU request becomes one word-aligned,
// byte-enabled RAM transaction, then a one-cycle done pulse.
// Ports:
//   clk, reset                         : clock, async active-high reset
//   start, op, addr, store_data, rt_old: CPU request (sampled in IDLE)
//   busy, done, load_result, addr_error: CPU status / result
//   address, read, write, writedata,
//   byteenable, readdata, waitrequest  : RAM side
//
// state        | meaning
// ST_IDLE      | waiting for start; request operands latched on start
// ST_REQ       | read or write held on the bus until waitrequest drops
// ST_WAIT_DATA | read accepted; readdata valid this cycle, captured
// ST_DONE      | done pulse; addr_error reported here
module mips_cpu_lsu
   import mips_cpu_lsu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  lsu_op_e     op,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   input  logic [31:0] rt_old,
   output logic        busy,
   output logic        done,
   output logic [31:0] load_result,
   output logic        addr_error,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] readdata,
   input  logic        waitrequest
);

   lsu_state_e  state_q, state_d;
   lsu_op_e     op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] store_data_q, store_data_d;
   logic [31:0] rt_old_q, rt_old_d;
   logic [31:0] load_result_q, load_result_d;
   logic        addr_error_q, addr_error_d;

   lsu_op_e     lane_op;
   logic [1:0]  lane_k;
   logic [3:0]  lane_be;
   logic [31:0] lane_wd;
   logic [31:0] lane_result;
   logic        lane_misaligned;

   // In IDLE the lane logic looks at the incoming request so the
   // alignment check is ready in the same cycle start is sampled.
   always_comb begin
      lane_op = (state_q == ST_IDLE) ? op        : op_q;
      lane_k  = (state_q == ST_IDLE) ? addr[1:0] : addr_q[1:0];
   end

   mips_cpu_lsu_lanes u_lanes (
      .op         (lane_op),
      .k          (lane_k),
      .store_data (store_data_q),
      .rt_old     (rt_old_q),
      .readdata   (readdata),
      .byteenable (lane_be),
      .writedata  (lane_wd),
      .result     (lane_result),
      .misaligned (lane_misaligned)
   );

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      addr_d        = addr_q;
      store_data_d  = store_data_q;
      rt_old_d      = rt_old_q;
      load_result_d = load_result_q;
      addr_error_d  = addr_error_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d         = op;
               addr_d       = addr;
               store_data_d = store_data;
               rt_old_d     = rt_old;
               if (lane_misaligned) begin
                  addr_error_d  = 1'b1;
                  load_result_d = 32'h0000_0000;
                  state_d       = ST_DONE;
               end else begin
                  addr_error_d  = 1'b0;
                  state_d       = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            // an op that is neither load nor store completes without data
            if (!waitrequest) begin
               state_d = is_load(op_q) ? ST_WAIT_DATA : ST_DONE;
            end
         end
         ST_WAIT_DATA: begin
            load_result_d = lane_result;
            state_d       = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         op_q          <= LSU_LB;
         addr_q        <= 32'h0000_0000;
         store_data_q  <= 32'h0000_0000;
         rt_old_q      <= 32'h0000_0000;
         load_result_q <= 32'h0000_0000;
         addr_error_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         addr_q        <= addr_d;
         store_data_q  <= store_data_d;
         rt_old_q      <= rt_old_d;
         load_result_q <= load_result_d;
         addr_error_q  <= addr_error_d;
      end
   end

   // Bus outputs decode straight from state so reset drops them at once.
   always_comb begin
      busy        = (state_q != ST_IDLE);
      done        = (state_q == ST_DONE);
      read        = (state_q == ST_REQ) && is_load(op_q);
      write       = (state_q == ST_REQ) && is_store(op_q);
      address     = {addr_q[31:2], 2'b00};
      byteenable  = (state_q == ST_REQ) ? lane_be : BE_NONE;
      writedata   = write ? lane_wd : 32'h0000_0000;
      load_result = load_result_q;
      addr_error  = done && addr_error_q;
   end

endmodule
